// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bus of the pipelined carry-lookahead adder.
// The producer/consumer side uses master, the adder itself uses slave.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             carry_in;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             PG;
    logic             GG;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in0, in1, carry_in, sub, in_valid, out_ready,
        input  in_ready, sum, carry_out, overflow, PG, GG, out_valid
    );

    modport slave (
        input  in0, in1, carry_in, sub, in_valid, out_ready,
        output in_ready, sum, carry_out, overflow, PG, GG, out_valid
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one SW-bit slice per stage, each slice built from
// GROUP-bit carry-lookahead blocks, with a single global stall (advance).
module pipelined_cla_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int SW   = WIDTH / STAGES;
    localparam int NGRP = SW / GROUP;

    // Returns {carry into slice MSB, carry out of slice, slice sum}.
    function automatic logic [SW+1:0] cla_slice(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          cin
    );
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW-1:0] s;
        logic [SW:0]   c;
        logic          gg;
        logic          gp;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int grp = 0; grp < NGRP; grp++) begin
            for (int j = 1; j <= GROUP; j++) begin
                gg = 1'b0;
                gp = 1'b1;
                for (int i = 0; i < j; i++) begin
                    gg = g[grp*GROUP+i] | (p[grp*GROUP+i] & gg);
                    gp = gp & p[grp*GROUP+i];
                end
                c[grp*GROUP+j] = gg | (gp & c[grp*GROUP]);
            end
        end
        s = p ^ c[SW-1:0];
        return {c[SW-1], c[SW], s};
    endfunction

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_d   [STAGES];
    logic             c_q   [STAGES];
    logic             z_d   [STAGES];
    logic             z_q   [STAGES];
    logic             pg_d  [STAGES];
    logic             pg_q  [STAGES];
    logic             ov_d  [STAGES];
    logic             ov_q  [STAGES];
    logic             vld_d [STAGES];
    logic             vld_q [STAGES];
    logic             advance;

    assign advance      = ~(vld_q[STAGES-1] & ~bus.out_ready);
    assign bus.in_ready = advance;

    always_comb begin
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             z_in;
        logic             pg_in;
        logic             v_in;
        logic [SW+1:0]    res;
        logic [SW+1:0]    resz;
        int               prv;
        a_in  = '0;
        b_in  = '0;
        s_in  = '0;
        c_in  = 1'b0;
        z_in  = 1'b0;
        pg_in = 1'b1;
        v_in  = 1'b0;
        res   = '0;
        resz  = '0;
        prv   = 0;
        for (int k = 0; k < STAGES; k++) begin
            prv = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                a_in  = bus.in0;
                b_in  = bus.sub ? ~bus.in1 : bus.in1;
                s_in  = '0;
                c_in  = bus.sub | bus.carry_in;
                z_in  = 1'b0;
                pg_in = 1'b1;
                v_in  = bus.in_valid;
            end else begin
                a_in  = a_q[prv];
                b_in  = b_q[prv];
                s_in  = s_q[prv];
                c_in  = c_q[prv];
                z_in  = z_q[prv];
                pg_in = pg_q[prv];
                v_in  = vld_q[prv];
            end
            // The cin=0 chain runs alongside the real one to yield full-width GG.
            res  = cla_slice(a_in[k*SW +: SW], b_in[k*SW +: SW], c_in);
            resz = cla_slice(a_in[k*SW +: SW], b_in[k*SW +: SW], z_in);

            a_d[k]             = a_in;
            b_d[k]             = b_in;
            s_d[k]             = s_in;
            s_d[k][k*SW +: SW] = res[SW-1:0];
            c_d[k]             = res[SW];
            z_d[k]             = resz[SW];
            pg_d[k]            = pg_in & (&(a_in[k*SW +: SW] ^ b_in[k*SW +: SW]));
            ov_d[k]            = res[SW+1] ^ res[SW];
            vld_d[k]           = v_in;
        end
    end

    // Stage boundary: every stage register holds together when the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                z_q[k]   <= 1'b0;
                pg_q[k]  <= 1'b0;
                ov_q[k]  <= 1'b0;
                vld_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                z_q[k]   <= z_d[k];
                pg_q[k]  <= pg_d[k];
                ov_q[k]  <= ov_d[k];
                vld_q[k] <= vld_d[k];
            end
        end
    end

    assign bus.sum       = s_q[STAGES-1];
    assign bus.carry_out = c_q[STAGES-1];
    assign bus.overflow  = ov_q[STAGES-1];
    assign bus.PG        = pg_q[STAGES-1];
    assign bus.GG        = z_q[STAGES-1];
    assign bus.out_valid = vld_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed table, stream, stall,
// mid-flight reset and randomized traffic against an arithmetic reference.
module tb_pipelined_cla_adder;
    localparam int WIDTH  = 64;
    localparam int STAGES = 4;
    localparam int GROUP  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ov;
        logic             pg;
        logic             gg;
    } res_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        res_t             exp;
    } vec_t;

    logic clk;
    logic rst_n;

    pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(GROUP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   n_got  = 0;
    int   first_got = -1;
    int   last_got  = -1;
    bit   acc_flag;
    bit   got_flag;
    bit   hold_pending = 0;
    res_t held;
    res_t last_out;
    res_t exp_q[$];

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        res_t                    r;
        logic        [WIDTH-1:0] bb;
        logic        [WIDTH:0]   full;
        logic        [WIDTH:0]   gen;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic signed [WIDTH-1:0] ss;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
        gen  = {1'b0, a} + {1'b0, bb};
        sa   = a;
        sb   = bb;
        ss   = full[WIDTH-1:0];
        r.sum = full[WIDTH-1:0];
        r.co  = full[WIDTH];
        r.ov  = ((sa < 0) == (sb < 0)) && ((ss < 0) != (sa < 0));
        r.pg  = &(a ^ bb);
        r.gg  = gen[WIDTH];
        return r;
    endfunction

    function automatic res_t dut_out();
        res_t r;
        r.sum = bus.sum;
        r.co  = bus.carry_out;
        r.ov  = bus.overflow;
        r.pg  = bus.PG;
        r.gg  = bus.GG;
        return r;
    endfunction

    task automatic check_res(input string name, input res_t act, input res_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sum=%h co=%b ov=%b PG=%b GG=%b, expected sum=%h co=%b ov=%b PG=%b GG=%b",
                     name, act.sum, act.co, act.ov, act.pg, act.gg,
                     exp.sum, exp.co, exp.ov, exp.pg, exp.gg);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Observes one cycle just before the rising edge, from a single process.
    task automatic observe();
        res_t act;
        act = dut_out();
        check_int("in_ready_rule", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
        if (hold_pending) begin
            check_int("stall_valid_hold", int'(bus.out_valid), 1);
            check_res("stall_data_hold", act, held);
            hold_pending = 0;
        end
        acc_flag = bus.in_valid && bus.in_ready;
        if (acc_flag) exp_q.push_back(model(bus.in0, bus.in1, bus.carry_in, bus.sub));
        got_flag = bus.out_valid && bus.out_ready;
        if (got_flag) begin
            last_out = act;
            n_got++;
            if (first_got < 0) first_got = cyc;
            last_got = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got sum=%h with nothing outstanding, expected no result", act.sum);
            end else begin
                check_res("scoreboard", act, exp_q.pop_front());
            end
        end
        if (bus.out_valid && !bus.out_ready) begin
            hold_pending = 1;
            held = act;
        end
    endtask

    // Called at negedge+1 with inputs set; returns at the next negedge+1.
    task automatic step();
        #3;
        observe();
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub);
        bus.in0      = a;
        bus.in1      = b;
        bus.carry_in = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_result(input string name, output int lat);
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (got_flag) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no result in 12 cycles, expected one", name);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int lat;
        int pending;
        int stall_cnt;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, '{64'h0, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{64'd5, 64'd7, 1'b0, 1'b1, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[3] = '{64'd7, 64'd5, 1'b0, 1'b1, '{64'd2, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, '{64'h0, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[6] = '{64'd0, 64'd0, 1'b0, 1'b1, '{64'h0, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1}};

        bus.in0 = '0; bus.in1 = '0; bus.carry_in = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_res("reset_outputs", dut_out(), '0);
        check_int("reset_out_valid", int'(bus.out_valid), 0);
        check_int("reset_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Directed table, one operation at a time.
        for (int v = 0; v < 8; v++) begin
            set_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub);
            step();
            check_int($sformatf("vec%0d_accept", v), int'(acc_flag), 1);
            bus.in_valid = 1'b0;
            wait_result($sformatf("vec%0d", v), lat);
            check_int($sformatf("vec%0d_latency", v), lat, STAGES);
            check_res($sformatf("vec%0d_table", v), last_out, vecs[v].exp);
        end

        // Back-to-back stream i+j.
        n_got = 0; first_got = -1; last_got = -1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                set_op(WIDTH'(i), WIDTH'(j), 1'b0, 1'b0);
                step();
                if (!acc_flag) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL stream_accept: got in_ready=0 at i=%0d j=%0d, expected 1", i, j);
                end
            end
        end
        bus.in_valid = 1'b0;
        for (int n = 0; n < 20 && n_got < 256; n++) step();
        check_int("stream_count", n_got, 256);
        check_int("stream_rate", last_got - first_got, 255);

        // Output stalled for 6 cycles while 5 operations are issued.
        n_got = 0; pending = 0; stall_cnt = 0;
        for (int n = 0; n < 40 && (n_got < 5 || pending < 5); n++) begin
            if (pending < 5) set_op(64'h1_0000_0000 * (pending + 1), 64'd3 + pending, 1'b1, 1'b0);
            else bus.in_valid = 1'b0;
            bus.out_ready = (stall_cnt >= 6);
            step();
            if (acc_flag) pending++;
            if (bus.out_valid && !bus.out_ready) stall_cnt++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check_int("stall_cycles", stall_cnt, 6);
        check_int("stall_delivered", n_got, 5);

        // Reset pulsed with 3 operations in flight.
        for (int n = 0; n < 3; n++) begin
            set_op(64'hDEAD_0000 + n, 64'h10, 1'b0, 1'b0);
            step();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_int("midreset_out_valid", int'(bus.out_valid), 0);
        check_res("midreset_outputs", dut_out(), '0);
        exp_q.delete();
        hold_pending = 0;
        #2;
        step();
        step();
        rst_n = 1'b1;
        set_op(64'h1234, 64'h4321, 1'b0, 1'b0);
        step();
        check_int("post_reset_accept", int'(acc_flag), 1);
        bus.in_valid = 1'b0;
        wait_result("post_reset", lat);
        check_int("post_reset_latency", lat, STAGES);
        check_int("post_reset_sum", int'(last_out.sum[31:0]), 32'h5555);
        for (int n = 0; n < 6; n++) step();

        // Randomized traffic with random back-pressure.
        for (int n = 0; n < 400; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = '1;
                2: rb = ~ra;
                3: ra = 64'h8000_0000_0000_0000;
                default: ;
            endcase
            set_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) step();
        check_int("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline segments; WIDTH divisible by STAGES, slice width SW = WIDTH/STAGES.
REQ-003 SHALL have parameter GROUP, default 4: carry-lookahead group size inside each slice; SW divisible by GROUP.
REQ-004 SHALL have port clk, input, 1: the one clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in0, input, WIDTH: operand A.
REQ-007 SHALL have port in1, input, WIDTH: operand B.
REQ-008 SHALL have port carry_in, input, 1: carry into bit 0; ignored when sub=1.
REQ-009 SHALL have port sub, input, 1: 0 = add, 1 = subtract (A - B).
REQ-010 SHALL have port in_valid, input, 1: operands present this cycle.
REQ-011 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-012 SHALL have port sum, output, WIDTH: result.
REQ-013 SHALL have port carry_out, output, 1: carry out of bit WIDTH-1.
REQ-014 SHALL have port overflow, output, 1: two's-complement signed overflow.
REQ-015 SHALL have port PG, output, 1: full-width group propagate.
REQ-016 SHALL have port GG, output, 1: full-width group generate.
REQ-017 SHALL have port out_valid, output, 1: result ports hold a valid result.
REQ-018 SHALL have port out_ready, input, 1: consumer takes result this cycle.

Function
REQ-019 SHALL form B' = sub ? ~in1 : in1 and cin = sub ? 1 : carry_in at acceptance.
REQ-020 SHALL compute per bit p = A ^ B', g = A & B'; PG = AND of all p; GG = carry out of full width with cin = 0.
REQ-021 SHALL produce sum = (A + B' + cin) mod 2^WIDTH; carry_out = GG | (PG & cin).
REQ-022 SHALL produce overflow = carry into bit WIDTH-1 XOR carry_out.
REQ-023 SHALL, in stage k (0..STAGES-1), add slice k with the carry registered from stage k-1 (stage 0 uses cin), using GROUP-bit lookahead; unprocessed upper slices and finished lower slices are carried in skew registers.
REQ-024 SHALL accept an operation on a rising edge where in_valid & in_ready = 1.
REQ-025 SHALL present a result with out_valid = 1 exactly STAGES cycles after acceptance when never stalled.
REQ-026 SHALL define advance = ~(out_valid & ~out_ready); in_ready = advance; when advance = 0 every pipeline register, including valid bits, holds.
REQ-027 SHALL, when advance = 1 and in_valid = 0, insert a bubble (stage valid 0); bubbles never assert out_valid.
REQ-028 SHALL sustain one result per cycle with in_valid and out_ready held high.
REQ-029 SHALL hold sum, carry_out, overflow, PG, GG stable while out_valid = 1 and out_ready = 0.
REQ-030 SHALL preserve issue order; no result dropped or duplicated under any in_valid/out_ready pattern.
REQ-031 SHALL, with STAGES = 1, behave as a single registered adder with latency 1.

Reset
REQ-032 SHALL, on rst_n = 0, immediately clear all stage valid bits and drive out_valid = 0, sum = 0, carry_out = 0, overflow = 0, PG = 0, GG = 0, independent of clk.
REQ-033 SHALL discard all in-flight operations when reset asserts mid-operation; none appear after release.
REQ-034 SHALL drive in_ready = 1 during and after reset (out_valid = 0).
REQ-035 SHALL accept a new operation on the first rising edge after rst_n deasserts.

Verification (WIDTH=64, STAGES=4, GROUP=4)
REQ-036 SHALL cover: in0=0xFFFF_FFFF_FFFF_FFFF, in1=1, carry_in=0, sub=0 -> 4 cycles later sum=0, carry_out=1, overflow=0, PG=0, GG=1.
REQ-037 SHALL cover: in0=0x7FFF_FFFF_FFFF_FFFF, in1=1, sub=0 -> sum=0x8000_0000_0000_0000, overflow=1, carry_out=0.
REQ-038 SHALL cover: in0=5, in1=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0; in0=7, in1=5, sub=1 -> sum=2, carry_out=1.
REQ-039 SHALL cover: back-to-back stream i+j for i,j in 0..15 with out_ready=1 -> 256 results in order, one per cycle after 4-cycle fill, all exact.
REQ-040 SHALL cover: out_ready=0 for 6 cycles with 5 operations in flight -> in_ready=0 while out_valid=1, outputs stable, all 5 results delivered in order after out_ready=1.
REQ-041 SHALL cover: rst_n pulsed low with 3 operations in flight -> out_valid=0 immediately, no stale result after release, next accepted op returns correct sum 4 cycles later.
